bcd_counter_disp: RTL and testbench
===================================

Name: bcd_counter_disp

Overview:
- Parametrised successor to the fixed 1 s / 500 ms dividers and the single-digit 7-segment decoder.
- Combines three functions in one block:
  - a programmable tick divider;
  - a DIGITS-wide BCD up/down counter with load, wrap and carry;
  - per-digit 7-segment encoding.
- Sits between the board clock and the HEX displays. Used for timers, stopwatches and lab counters.

Parameters:
- CLK_HZ, 50000000: input clock frequency in Hz.
- TICK_HZ, 1: count-step rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be >= 2 (elaboration error otherwise).
- DIGITS, 4: number of BCD digits, 1..8.
- SEG_ACTIVE_LOW, 0: 0 = segment on when bit is 1; 1 = all hex bits inverted.

Ports:
- clk_50  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; gates both the divider and the stepping.
- up  in  1  direction: 1 = up, 0 = down; sampled at the step edge.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD load value; digit 0 in bits [3:0].
- bcd  out  4*DIGITS  current count, registered; digit 0 in bits [3:0].
- hex  out  7*DIGITS  segment patterns; digit i in bits [7i+6:7i], bit order g..a.
- tick  out  1  one-cycle pulse on each count step.
- carry  out  1  one-cycle pulse on wrap or borrow-out.

Behaviour:
- Reset (clr=1, takes effect immediately, no clock edge needed):
  - divider count = 0; bcd = 0; tick = 0; carry = 0.
  - hex = 7'b0111111 per digit, or its inverse when SEG_ACTIVE_LOW=1.
- Divider:
  - Width is $clog2(DIV).
  - If en=1: increments each edge. When it reaches DIV-1, the next edge returns it to 0 and that edge is a "step edge".
  - If en=0: divider holds its value; no steps occur.
- Step edge:
  - bcd updates; tick=1 for exactly that following cycle.
  - First step occurs at the DIV-th edge after en rises from a cleared divider.
- Up count:
  - Digit 0 +1. A digit at 9 becomes 0 and carries into the next digit.
  - All-9s becomes all-0s and carry=1 alongside tick.
- Down count:
  - Digit 0 -1. A digit at 0 becomes 9 and borrows from the next digit.
  - All-0s becomes all-9s and carry=1.
- Load (priority over step and over en):
  - bcd <= load_val, with every nibble >9 replaced by 0.
  - Divider cleared to 0; tick=0 and carry=0 next cycle.
- Simultaneous load and step edge: load wins; no tick or carry is issued.
- tick and carry are registered and never high for more than 1 consecutive cycle (given DIV >= 2).
- Direction change takes effect at the next step edge only.
- hex:
  - Combinational from bcd.
  - Encoding 0..9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
  - Other codes (unreachable) output 0000000, before optional inversion.
- Reset mid-count: all state returns to reset values. Counting resumes from 0 with the divider cleared after clr drops.

Test Plan (CLK_HZ=10, TICK_HZ=1 so DIV=10; DIGITS=4 unless stated):
- clr=1 pulse, no clock edge -> bcd=16'h0000, tick=0, carry=0, hex=4x 7'b0111111 immediately.
- en=1, up=1 from reset -> tick on edges 10, 20, 30; bcd=16'h0003 after 30 edges; carry stays 0.
- load 16'h0999, then one step up -> 16'h1000, carry=0. Load 16'h9999, then one step up -> 16'h0000, carry=1 for one cycle coincident with tick.
- up=0 from 16'h0000 -> 16'h9999 with carry=1. Load 16'h1A05 -> bcd=16'h1005. Load asserted on a step edge -> bcd=load value, tick=0.
- en=0 for 25 cycles after divider=4 -> no tick, bcd unchanged; next tick 6 edges after en returns. Assert clr mid-interval -> outputs zero without an edge.
- SEG_ACTIVE_LOW=1, DIGITS=2, load 16'h0008 -> hex[6:0]=7'b0000000, hex[13:7]=7'b1000000.

Source files
------------

// File: rtl/bcd_counter_disp.sv
// Programmable tick divider driving a DIGITS-wide BCD up/down counter with
// synchronous load, wrap/borrow carry and per-digit 7-segment encoding.
module bcd_counter_disp #(
    parameter int CLK_HZ         = 50000000,
    parameter int TICK_HZ        = 1,
    parameter int DIGITS         = 4,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk_50,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  tick,
    output logic                  carry
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    generate
        if (DIV < 2 || DIGITS < 1 || DIGITS > 8) begin : g_bad_param
            $error("bcd_counter_disp: need CLK_HZ/TICK_HZ >= 2 and DIGITS in 1..8");
        end
    endgenerate

    logic [DW-1:0]       div_cnt;
    logic                step;
    logic [4*DIGITS-1:0] bcd_next;
    logic [4*DIGITS-1:0] load_clean;
    logic                wrap;
    logic [7*DIGITS-1:0] hex_raw;

    assign step = en && (div_cnt == DIV_LAST);

    // Ripple the +/-1 through the digits; wrap is the carry/borrow out of the top digit.
    always_comb begin
        logic       prop;
        logic [3:0] d;
        bcd_next   = '0;
        load_clean = '0;
        prop       = 1'b1;
        d          = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = bcd[4*i +: 4];
            if (prop) begin
                if (up) begin
                    if (d >= 4'd9) begin
                        bcd_next[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_next[4*i +: 4] = d + 4'd1;
                        prop = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        bcd_next[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_next[4*i +: 4] = d - 4'd1;
                        prop = 1'b0;
                    end
                end
            end else begin
                bcd_next[4*i +: 4] = d;
            end
            load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
        end
        wrap = prop;
    end

    always_ff @(posedge clk_50 or posedge clr) begin
        if (clr) begin
            div_cnt <= '0;
            bcd     <= '0;
            tick    <= 1'b0;
            carry   <= 1'b0;
        end else if (load) begin
            div_cnt <= '0;
            bcd     <= load_clean;
            tick    <= 1'b0;
            carry   <= 1'b0;
        end else begin
            tick  <= 1'b0;
            carry <= 1'b0;
            if (en) begin
                if (step) begin
                    div_cnt <= '0;
                    bcd     <= bcd_next;
                    tick    <= 1'b1;
                    carry   <= wrap;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hex_raw = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            case (bcd[4*i +: 4])
                4'd0:    hex_raw[7*i +: 7] = 7'b0111111;
                4'd1:    hex_raw[7*i +: 7] = 7'b0000110;
                4'd2:    hex_raw[7*i +: 7] = 7'b1011011;
                4'd3:    hex_raw[7*i +: 7] = 7'b1001111;
                4'd4:    hex_raw[7*i +: 7] = 7'b1100110;
                4'd5:    hex_raw[7*i +: 7] = 7'b1101101;
                4'd6:    hex_raw[7*i +: 7] = 7'b1111101;
                4'd7:    hex_raw[7*i +: 7] = 7'b0000111;
                4'd8:    hex_raw[7*i +: 7] = 7'b1111111;
                4'd9:    hex_raw[7*i +: 7] = 7'b1101111;
                default: hex_raw[7*i +: 7] = 7'b0000000;
            endcase
        end
    end

    assign hex = (SEG_ACTIVE_LOW != 0) ? ~hex_raw : hex_raw;

endmodule

// File: tb/tb_bcd_counter_disp.sv
// Bench for bcd_counter_disp: directed scenarios plus random stimulus against
// an integer-valued model of the counter (DIV=10, 4 digits; second 2-digit active-low copy).
module tb_bcd_counter_disp;

    localparam int DIV = 10;

    logic        clk_50 = 1'b0;
    logic        clr = 1'b0;
    logic        en = 1'b0, up = 1'b1, load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] bcd;
    logic [27:0] hex;
    logic        tick, carry;

    logic        en2 = 1'b0, up2 = 1'b1, load2 = 1'b0;
    logic [7:0]  load_val2 = '0;
    logic [7:0]  bcd2;
    logic [13:0] hex2;
    logic        tick2, carry2;

    int checks = 0;
    int errors = 0;

    int m_val = 0;
    int m_div = 0;
    bit m_tick = 0;
    bit m_carry = 0;

    always #5 clk_50 = ~clk_50;

    bcd_counter_disp #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(4), .SEG_ACTIVE_LOW(0)) dut (
        .clk_50(clk_50), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd), .hex(hex), .tick(tick), .carry(carry)
    );

    bcd_counter_disp #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .SEG_ACTIVE_LOW(1)) dut2 (
        .clk_50(clk_50), .clr(clr), .en(en2), .up(up2), .load(load2), .load_val(load_val2),
        .bcd(bcd2), .hex(hex2), .tick(tick2), .carry(carry2)
    );

    function automatic logic [6:0] seg(input int d);
        logic [6:0] t [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
        return t[d];
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] to_hex(input int v);
        logic [27:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[7*i +: 7] = seg(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int load_dec(input logic [15:0] lv);
        int v = 0;
        int mult = 1;
        int n;
        for (int i = 0; i < 4; i++) begin
            n = int'(lv[4*i +: 4]);
            if (n > 9) n = 0;
            v += n * mult;
            mult *= 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_val = 0; m_div = 0; m_tick = 0; m_carry = 0;
    endtask

    // One clock edge; the model follows the counting rules in decimal arithmetic.
    task automatic clk_edge();
        @(posedge clk_50);
        m_tick = 0;
        m_carry = 0;
        if (load) begin
            m_val = load_dec(load_val);
            m_div = 0;
        end else if (en) begin
            if (m_div == DIV - 1) begin
                m_div = 0;
                m_tick = 1;
                if (up) begin
                    m_carry = (m_val == 9999);
                    m_val = (m_val + 1) % 10000;
                end else begin
                    m_carry = (m_val == 0);
                    m_val = (m_val + 9999) % 10000;
                end
            end else begin
                m_div++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #1 clr = 1'b1;
        #1;
        model_reset();
        checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got %h want 0000", bcd); end
        checks++; if (tick !== 1'b0 || carry !== 1'b0) begin errors++; $display("FAIL reset_pulses got tick=%b carry=%b want 0 0", tick, carry); end
        checks++; if (hex !== {4{7'b0111111}}) begin errors++; $display("FAIL reset_hex got %h want %h", hex, {4{7'b0111111}}); end
        checks++; if (hex2 !== ~{2{7'b0111111}}) begin errors++; $display("FAIL reset_hex_low got %h want %h", hex2, ~{2{7'b0111111}}); end
        #1 clr = 1'b0;
    endtask

    task automatic test_count_up();
        en = 1'b1; up = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            clk_edge();
            checks++;
            if (tick !== ((n % 10) == 0)) begin errors++; $display("FAIL up_tick edge %0d got %b want %b", n, tick, (n % 10) == 0); end
            checks++;
            if (carry !== 1'b0) begin errors++; $display("FAIL up_carry edge %0d got %b want 0", n, carry); end
        end
        checks++; if (bcd !== 16'h0003) begin errors++; $display("FAIL up_bcd got %h want 0003", bcd); end
    endtask

    task automatic wait_step(input string name, output bit seen);
        seen = 0;
        for (int n = 0; n < DIV + 2 && !seen; n++) begin
            clk_edge();
            if (tick === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL %s_timeout got no tick want tick within %0d edges", name, DIV + 2); end
    endtask

    task automatic test_load_wrap();
        bit seen;
        up = 1'b1;
        load = 1'b1; load_val = 16'h0999; clk_edge(); load = 1'b0;
        checks++; if (bcd !== 16'h0999 || tick !== 1'b0) begin errors++; $display("FAIL load0999 got %h tick=%b want 0999 tick=0", bcd, tick); end
        wait_step("step1000", seen);
        checks++; if (bcd !== 16'h1000 || carry !== 1'b0) begin errors++; $display("FAIL step1000 got %h carry=%b want 1000 carry=0", bcd, carry); end
        load = 1'b1; load_val = 16'h9999; clk_edge(); load = 1'b0;
        wait_step("wrap_up", seen);
        checks++; if (bcd !== 16'h0000 || carry !== 1'b1) begin errors++; $display("FAIL wrap_up got %h carry=%b want 0000 carry=1", bcd, carry); end
        clk_edge();
        checks++; if (carry !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL wrap_up_pulse got tick=%b carry=%b want 0 0", tick, carry); end
    endtask

    task automatic test_down_and_load();
        bit seen;
        up = 1'b0;
        wait_step("wrap_down", seen);
        checks++; if (bcd !== 16'h9999 || carry !== 1'b1) begin errors++; $display("FAIL wrap_down got %h carry=%b want 9999 carry=1", bcd, carry); end
        load = 1'b1; load_val = 16'h1A05; clk_edge(); load = 1'b0;
        checks++; if (bcd !== 16'h1005) begin errors++; $display("FAIL load_sanitize got %h want 1005", bcd); end
        for (int n = 0; n < DIV - 1; n++) clk_edge();
        load = 1'b1; load_val = 16'h0042; clk_edge(); load = 1'b0;
        checks++; if (bcd !== 16'h0042 || tick !== 1'b0 || carry !== 1'b0) begin errors++; $display("FAIL load_on_step got %h tick=%b carry=%b want 0042 0 0", bcd, tick, carry); end
    endtask

    task automatic test_enable_hold();
        int cnt;
        bit seen;
        up = 1'b1;
        load = 1'b1; load_val = 16'h0500; clk_edge(); load = 1'b0;
        for (int n = 0; n < 4; n++) clk_edge();
        en = 1'b0;
        for (int n = 0; n < 25; n++) begin
            clk_edge();
            checks++;
            if (tick !== 1'b0 || bcd !== 16'h0500) begin errors++; $display("FAIL en_hold cycle %0d got %h tick=%b want 0500 tick=0", n, bcd, tick); end
        end
        en = 1'b1;
        cnt = 0; seen = 0;
        while (!seen && cnt < 20) begin
            clk_edge(); cnt++;
            if (tick === 1'b1) seen = 1;
        end
        checks++; if (cnt !== 6 || !seen) begin errors++; $display("FAIL en_resume got %0d edges want 6", cnt); end
        checks++; if (bcd !== 16'h0501) begin errors++; $display("FAIL en_resume_bcd got %h want 0501", bcd); end
    endtask

    task automatic test_clr_mid();
        bit seen;
        int cnt;
        for (int n = 0; n < 7; n++) clk_edge();
        #1 clr = 1'b1;
        #1;
        model_reset();
        checks++; if (bcd !== 16'h0000 || tick !== 1'b0 || carry !== 1'b0 || hex !== {4{7'b0111111}}) begin
            errors++; $display("FAIL clr_mid got %h tick=%b carry=%b hex=%h want 0000 0 0 %h", bcd, tick, carry, hex, {4{7'b0111111}});
        end
        #1 clr = 1'b0;
        cnt = 0; seen = 0;
        while (!seen && cnt < 20) begin
            clk_edge(); cnt++;
            if (tick === 1'b1) seen = 1;
        end
        checks++; if (cnt !== DIV || bcd !== 16'h0001) begin errors++; $display("FAIL clr_resume got %0d edges bcd=%h want %0d edges bcd=0001", cnt, bcd, DIV); end
    endtask

    task automatic test_seg_low();
        load2 = 1'b1; load_val2 = 8'h08; clk_edge(); load2 = 1'b0;
        checks++; if (hex2[6:0] !== 7'b0000000) begin errors++; $display("FAIL seg_low_d0 got %b want 0000000", hex2[6:0]); end
        checks++; if (hex2[13:7] !== 7'b1000000) begin errors++; $display("FAIL seg_low_d1 got %b want 1000000", hex2[13:7]); end
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 1500; n++) begin
            en = ($urandom_range(0, 7) != 0);
            up = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 31) == 0);
            sel = int'($urandom_range(0, 3));
            load_val = (sel == 0) ? 16'h9999 : (sel == 1) ? 16'h0000 : 16'($urandom);
            clk_edge();
            checks++;
            if (bcd !== to_bcd(m_val) || tick !== m_tick || carry !== m_carry) begin
                errors++;
                $display("FAIL random cycle %0d got bcd=%h tick=%b carry=%b want bcd=%h tick=%b carry=%b",
                         n, bcd, tick, carry, to_bcd(m_val), m_tick, m_carry);
            end
            checks++;
            if (hex !== to_hex(m_val)) begin errors++; $display("FAIL random_hex cycle %0d got %h want %h", n, hex, to_hex(m_val)); end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_wrap();
        test_down_and_load();
        test_enable_hold();
        test_clr_mid();
        test_seg_low();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
